// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RISC-V load/store at a time, checks alignment and range,
// drives a single-cycle access to a byte-addressed data memory and returns an extended result.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DMEM_SIZE  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_read,
    output logic [1:0]            mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int AW = DATA_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_reg, state_next;
    logic                    we_reg;
    logic [2:0]              funct3_reg;
    logic [DATA_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH-1:0]   resp_rdata_reg;
    logic                    resp_err_reg;

    logic                    accept;
    logic                    funct3_bad;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    req_err;
    logic [2:0]              size_bytes;
    logic [AW-1:0]           last_byte;
    logic [1:0]              size_code;
    logic [DATA_WIDTH-1:0]   load_ext;

    assign accept = req_valid && (state_reg == IDLE);

    // Request validation; the range check is one bit wider so addresses near the top cannot wrap.
    always_comb begin
        funct3_bad = req_we ? (req_funct3 > 3'b010)
                            : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));
        case (req_funct3[1:0])
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        last_byte    = {1'b0, req_addr} + AW'(size_bytes) - AW'(1);
        out_of_range = last_byte >= AW'(DMEM_SIZE);
        req_err      = funct3_bad || misaligned || out_of_range;
    end

    always_comb begin
        case (funct3_reg)
            3'b000:  load_ext = {{(DATA_WIDTH-8){mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){mem_rdata[15]}}, mem_rdata[15:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, mem_rdata[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    assign size_code = funct3_reg[1:0] + 2'b01;

    always_comb begin
        state_next = state_reg;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_read   = 3'b000;
        mem_write  = 2'b00;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_addr   = addr_reg;
                state_next = RESP;
                if (we_reg) begin
                    mem_write = size_code;
                    mem_wdata = wdata_reg;
                end else begin
                    mem_read = {~funct3_reg[2] && (funct3_reg[1:0] != 2'b10), size_code};
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            funct3_reg     <= 3'b000;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg         <= req_we;
                funct3_reg     <= req_funct3;
                addr_reg       <= req_addr;
                wdata_reg      <= req_wdata;
                resp_err_reg   <= req_err;
                resp_rdata_reg <= '0;
            end else if (state_reg == ACCESS) begin
                resp_rdata_reg <= we_reg ? '0 : load_ext;
            end else if ((state_reg == RESP) && resp_ready) begin
                resp_rdata_reg <= '0;
                resp_err_reg   <= 1'b0;
            end
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests against a little-endian byte memory model,
// with responses checked by a scoreboard monitor decoupled from the driver.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] mem_rdata;

    int total_checks  = 0;
    int passed_checks = 0;

    logic [7:0]  dmem [1024];
    logic [32:0] sb_q [$];

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .DMEM_SIZE(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    // Raw little-endian word at mem_addr; the unit does its own extension.
    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (mem_addr + 32'(i) < 32'd1024) mem_rdata[8*i +: 8] = dmem[mem_addr + 32'(i)];
        end
    end

    always @(posedge clk) begin
        if (mem_write != 2'b00) begin
            for (int i = 0; i < 4; i++) begin
                if ((i < (mem_write == 2'b01 ? 1 : mem_write == 2'b10 ? 2 : 4)) &&
                    (mem_addr + 32'(i) < 32'd1024))
                    dmem[mem_addr + 32'(i)] <= mem_wdata[8*i +: 8];
            end
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endfunction

    // Response monitor: pops one expectation per completed handshake.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                check("resp_err", 32'(resp_err), 32'(e[32]));
                check("resp_rdata", resp_rdata, e[31:0]);
                $display("resp: err=%0d rdata=0x%08h (expected err=%0d rdata=0x%08h)",
                         resp_err, resp_rdata, e[32], e[31:0]);
            end
        end
    end

    // Issue one request starting at a negedge; checks memory-port activity and latency.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input bit ee, input logic [2:0] emr, input logic [1:0] emw);
        int lat;
        int acc;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFF0;
        req_wdata  = 32'h5555_AAAA;
        sb_q.push_back({ee, er});
        $display("req: we=%0d f3=%03b addr=0x%08h wdata=0x%08h", we, f3, a, wd);
        lat = 0;
        acc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_read != 3'b000 || mem_write != 2'b00) begin
                acc++;
                check("mem_read", 32'(mem_read), 32'(emr));
                check("mem_write", 32'(mem_write), 32'(emw));
                check("mem_addr", mem_addr, a);
                check("mem_wdata", mem_wdata, we ? wd : 32'd0);
            end
        end while (!resp_valid && lat < 10);
        check("resp_latency", 32'(lat), ee ? 32'd1 : 32'd2);
        check("mem_accesses", 32'(acc), ee ? 32'd0 : 32'd1);
        @(posedge clk);
        #1;
        check("resp_valid_drop", 32'(resp_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) dmem[i] = 8'h00;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_port", {mem_addr[15:0], mem_wdata[10:0], mem_read, mem_write}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, 3'b000, 2'b11);
        do_req(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, 3'b011, 2'b00);
        do_req(1, 3'b000, 32'h21,  32'h80,       32'h0,        0, 3'b000, 2'b01);
        do_req(0, 3'b000, 32'h21,  32'h0,        32'hFFFFFF80, 0, 3'b101, 2'b00);
        do_req(0, 3'b100, 32'h21,  32'h0,        32'h00000080, 0, 3'b001, 2'b00);
        do_req(1, 3'b001, 32'h30,  32'h00008001, 32'h0,        0, 3'b000, 2'b10);
        do_req(0, 3'b001, 32'h30,  32'h0,        32'hFFFF8001, 0, 3'b110, 2'b00);
        do_req(0, 3'b101, 32'h30,  32'h0,        32'h00008001, 0, 3'b010, 2'b00);
        do_req(0, 3'b001, 32'h13,  32'h0,        32'h0,        1, 3'b000, 2'b00);
        do_req(0, 3'b010, 32'h22,  32'h0,        32'h0,        1, 3'b000, 2'b00);
        do_req(1, 3'b010, 32'h3FE, 32'h12345678, 32'h0,        1, 3'b000, 2'b00);
        do_req(0, 3'b011, 32'h0,   32'h0,        32'h0,        1, 3'b000, 2'b00);
        do_req(1, 3'b100, 32'h0,   32'h0,        32'h0,        1, 3'b000, 2'b00);
        do_req(1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0,        0, 3'b000, 2'b11);
        do_req(0, 3'b010, 32'h3FC, 32'h0,        32'hCAFEF00D, 0, 3'b011, 2'b00);
        do_req(0, 3'b010, 32'h400, 32'h0,        32'h0,        1, 3'b000, 2'b00);
        do_req(1, 3'b000, 32'hFFFFFFFF, 32'h77,  32'h0,        1, 3'b000, 2'b00);
        do_req(0, 3'b000, 32'h3FF, 32'h0,        32'hFFFFFFCA, 0, 3'b101, 2'b00);

        // Response back-pressure with a competing request held on the bus.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        @(posedge clk);
        #1;
        sb_q.push_back({1'b0, 32'hDEADBEEF});
        req_funct3 = 3'b000;
        req_addr   = 32'h21;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall_resp_valid", 32'(resp_valid), 32'd1);
            check("stall_resp_rdata", resp_rdata, 32'hDEADBEEF);
            check("stall_resp_err", 32'(resp_err), 32'd0);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge clk);
        #1;
        check("stall_done_valid", 32'(resp_valid), 32'd0);
        check("stall_done_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Reset in the middle of a store access.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("pre_rst_mem_write", 32'(mem_write), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_write", 32'(mem_write), 32'd0);
        check("rst_mid_mem_addr", mem_addr, 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_resp", 32'(resp_valid), 32'd0);
        check("rst_rel_req_ready", 32'(req_ready), 32'd1);
        do_req(0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 3'b011, 2'b00);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
